// File: rtl/decode_stage_p_pkg.sv
// decode_stage_p_pkg: shared widths, opcodes and control encodings for the decode stage.
package decode_stage_p_pkg;
    localparam int DW_D   = 32;
    localparam int NREG_D = 32;
    localparam int PCW_D  = 12;
    localparam int CTLW_D = 9;

    typedef enum logic [5:0] {
        OP_R    = 6'b000000,
        OP_LW   = 6'b100011,
        OP_SW   = 6'b101011,
        OP_BEQ  = 6'b000100,
        OP_ADDI = 6'b001000
    } opcode_e;

    localparam int C_REGDST   = 8;
    localparam int C_ALUSRC   = 7;
    localparam int C_MEMTOREG = 6;
    localparam int C_REGWRITE = 5;
    localparam int C_MEMREAD  = 4;
    localparam int C_MEMWRITE = 3;
    localparam int C_BRANCH   = 2;
    localparam int C_ALUOP    = 0;

    localparam logic [8:0] CTL_R    = 9'b100100010;
    localparam logic [8:0] CTL_LW   = 9'b011110000;
    localparam logic [8:0] CTL_SW   = 9'b010001000;
    localparam logic [8:0] CTL_BEQ  = 9'b000000101;
    localparam logic [8:0] CTL_ADDI = 9'b010100000;

    function automatic logic [8:0] decode_ctl(input logic [5:0] op);
        return op == OP_R    ? CTL_R    :
               op == OP_LW   ? CTL_LW   :
               op == OP_SW   ? CTL_SW   :
               op == OP_BEQ  ? CTL_BEQ  :
               op == OP_ADDI ? CTL_ADDI : 9'b0;
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return op == OP_R || op == OP_SW || op == OP_BEQ;
    endfunction
endpackage

// File: rtl/decode_stage_p_if.sv
// decode_stage_p_if: IF/ID input, ID/EX output and write-back port bundle.
interface decode_stage_p_if
    import decode_stage_p_pkg::*;
#(
    parameter int DW   = DW_D,
    parameter int NREG = NREG_D,
    parameter int PCW  = PCW_D,
    parameter int CTLW = CTLW_D
);
    localparam int AW = $clog2(NREG);
    logic            if_valid;
    logic [31:0]     if_ir;
    logic [PCW-1:0]  if_npc;
    logic            id_ready;
    logic            ex_ready;
    logic            flush;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic            idex_valid;
    logic [DW-1:0]   idex_a;
    logic [DW-1:0]   idex_b;
    logic [DW-1:0]   idex_imm;
    logic [AW-1:0]   idex_rt;
    logic [AW-1:0]   idex_rd;
    logic [PCW-1:0]  idex_npc;
    logic [CTLW-1:0] idex_ctl;

    modport slave (
        input  if_valid, if_ir, if_npc, ex_ready, flush, wb_we, wb_addr, wb_data,
        output id_ready, idex_valid, idex_a, idex_b, idex_imm, idex_rt, idex_rd, idex_npc, idex_ctl
    );
    modport master (
        output if_valid, if_ir, if_npc, ex_ready, flush, wb_we, wb_addr, wb_data,
        input  id_ready, idex_valid, idex_a, idex_b, idex_imm, idex_rt, idex_rd, idex_npc, idex_ctl
    );
endinterface

// File: rtl/decode_stage_p_regfile.sv
// regfile_p: NREG x DW register file, two combinational reads, one write, write-through.
module regfile_p #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_ra0,
    input  logic [AW-1:0] i_ra1,
    output logic [DW-1:0] o_rd0,
    output logic [DW-1:0] o_rd1,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [DW-1:0] i_wd
);
    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        else if (i_we && i_wa != '0)
            r_mem[i_wa] <= i_wd;
    end

    // Same-cycle write-back is forwarded so decode never sees a stale value.
    assign o_rd0 = i_ra0 == '0 ? '0 : (i_we && i_wa == i_ra0) ? i_wd : r_mem[i_ra0];
    assign o_rd1 = i_ra1 == '0 ? '0 : (i_we && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: instruction decode with register read, load-use stall and ID/EX register.
module decode_stage_p
    import decode_stage_p_pkg::*;
#(
    parameter int DW   = DW_D,
    parameter int NREG = NREG_D,
    parameter int PCW  = PCW_D,
    parameter int CTLW = CTLW_D
) (
    input logic              clk,
    input logic              rst_n,
    decode_stage_p_if.slave  io_bus
);
    localparam int AW = $clog2(NREG);

    logic [5:0]      w_op;
    logic [AW-1:0]   w_rs, w_rt, w_rd;
    logic [DW-1:0]   w_a, w_b, w_imm;
    logic [CTLW-1:0] w_ctl;
    logic            w_hazard, w_advance;

    logic            r_valid;
    logic [DW-1:0]   r_a, r_b, r_imm;
    logic [AW-1:0]   r_rt, r_rd;
    logic [PCW-1:0]  r_npc;
    logic [CTLW-1:0] r_ctl;

    assign w_op  = io_bus.if_ir[31:26];
    assign w_rs  = AW'(io_bus.if_ir[25:21]);
    assign w_rt  = AW'(io_bus.if_ir[20:16]);
    assign w_rd  = AW'(io_bus.if_ir[15:11]);
    assign w_imm = {{(DW-16){io_bus.if_ir[15]}}, io_bus.if_ir[15:0]};
    assign w_ctl = CTLW'(decode_ctl(w_op));

    regfile_p #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra0 (w_rs),
        .i_ra1 (w_rt),
        .o_rd0 (w_a),
        .o_rd1 (w_b),
        .i_we  (io_bus.wb_we),
        .i_wa  (io_bus.wb_addr),
        .i_wd  (io_bus.wb_data)
    );

    // A load in EX cannot forward in time; rt only counts when the opcode reads it.
    assign w_hazard  = r_valid && r_ctl[C_MEMREAD] && r_rt != '0 &&
                       (r_rt == w_rs || (uses_rt(w_op) && r_rt == w_rt));
    assign w_advance = !r_valid || io_bus.ex_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_npc   <= '0;
            r_ctl   <= '0;
        end else if (io_bus.flush || (w_advance && w_hazard)) begin
            r_valid <= 1'b0;
            r_ctl   <= '0;
        end else if (w_advance) begin
            r_valid <= io_bus.if_valid;
            r_a     <= w_a;
            r_b     <= w_b;
            r_imm   <= w_imm;
            r_rt    <= w_rt;
            r_rd    <= w_rd;
            r_npc   <= io_bus.if_npc;
            r_ctl   <= w_ctl;
        end
    end

    assign io_bus.id_ready   = w_advance && !w_hazard && !io_bus.flush;
    assign io_bus.idex_valid = r_valid;
    assign io_bus.idex_a     = r_a;
    assign io_bus.idex_b     = r_b;
    assign io_bus.idex_imm   = r_imm;
    assign io_bus.idex_rt    = r_rt;
    assign io_bus.idex_rd    = r_rd;
    assign io_bus.idex_npc   = r_npc;
    assign io_bus.idex_ctl   = r_ctl;
endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed checks of decode, write-through, stalls, flush and reset.
module tb_decode_stage_p;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    decode_stage_p_if bus ();
    decode_stage_p dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.if_valid = 1'b0; bus.if_ir = '0; bus.if_npc = '0; bus.ex_ready = 1'b1;
        bus.flush = 1'b0; bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        #12;
        chk("rst_valid", bus.idex_valid, 0);
        chk("rst_a", bus.idex_a, 0);
        chk("rst_b", bus.idex_b, 0);
        chk("rst_imm", bus.idex_imm, 0);
        chk("rst_rt", bus.idex_rt, 0);
        chk("rst_rd", bus.idex_rd, 0);
        chk("rst_npc", bus.idex_npc, 0);
        chk("rst_ctl", bus.idex_ctl, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", bus.id_ready, 1);
        // write-through R5 while decoding R-type rs=5
        bus.if_valid = 1'b1; bus.if_ir = r_ins(5, 6, 7); bus.if_npc = 12'h004;
        bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0000_00AA;
        tick();
        chk("wt_valid", bus.idex_valid, 1);
        chk("wt_a", bus.idex_a, 32'hAA);
        chk("wt_b", bus.idex_b, 0);
        chk("wt_rt", bus.idex_rt, 6);
        chk("wt_rd", bus.idex_rd, 7);
        chk("wt_npc", bus.idex_npc, 12'h004);
        chk("wt_ctl", bus.idex_ctl, 9'b100100010);
        bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF; bus.if_ir = r_ins(0, 5, 0);
        tick();
        chk("r0_a", bus.idex_a, 0);
        chk("r5_held", bus.idex_b, 32'hAA);
        bus.wb_we = 1'b0;
        tick();
        chk("r0_after", bus.idex_a, 0);
        bus.if_ir = i_ins(6'b001000, 5, 8, 16'hFFF0);
        tick();
        chk("addi_imm", bus.idex_imm, 32'hFFFF_FFF0);
        chk("addi_ctl", bus.idex_ctl, 9'b010100000);
        chk("addi_a", bus.idex_a, 32'hAA);
        chk("addi_rt", bus.idex_rt, 8);
        bus.if_ir = i_ins(6'b111111, 1, 2, 16'h0001);
        tick();
        chk("undef_ctl", bus.idex_ctl, 0);
        // load-use stall
        bus.if_ir = i_ins(6'b100011, 0, 3, 16'h0004);
        tick();
        chk("lw_ctl", bus.idex_ctl, 9'b011110000);
        chk("lw_rt", bus.idex_rt, 3);
        bus.if_ir = r_ins(3, 1, 2);
        #1;
        chk("lu_ready", bus.id_ready, 0);
        tick();
        chk("lu_bubble_v", bus.idex_valid, 0);
        chk("lu_bubble_c", bus.idex_ctl, 0);
        chk("lu_ready2", bus.id_ready, 1);
        tick();
        chk("lu_acc_v", bus.idex_valid, 1);
        chk("lu_acc_rd", bus.idex_rd, 2);
        chk("lu_acc_ctl", bus.idex_ctl, 9'b100100010);
        bus.if_ir = i_ins(6'b100011, 0, 3, 16'h0004);
        tick();
        bus.if_ir = i_ins(6'b001000, 0, 3, 16'h0001);
        #1;
        chk("lu_addi_ready", bus.id_ready, 1);
        tick();
        chk("lu_addi_ctl", bus.idex_ctl, 9'b010100000);
        // backpressure
        bus.ex_ready = 1'b0; bus.if_ir = r_ins(5, 0, 9);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", bus.id_ready, 0);
            tick();
            chk("bp_imm", bus.idex_imm, 1);
            chk("bp_ctl", bus.idex_ctl, 9'b010100000);
        end
        bus.ex_ready = 1'b1;
        #1;
        chk("bp_ready_rel", bus.id_ready, 1);
        tick();
        chk("bp_acc_rd", bus.idex_rd, 9);
        chk("bp_acc_ctl", bus.idex_ctl, 9'b100100010);
        // flush with stall
        bus.ex_ready = 1'b0; bus.flush = 1'b1; bus.if_ir = i_ins(6'b001000, 5, 10, 16'h0123);
        #1;
        chk("fl_ready", bus.id_ready, 0);
        tick();
        chk("fl_valid", bus.idex_valid, 0);
        chk("fl_ctl", bus.idex_ctl, 0);
        bus.flush = 1'b0;
        #1;
        chk("fl_ready2", bus.id_ready, 1);
        tick();
        chk("fl_acc_v", bus.idex_valid, 1);
        chk("fl_acc_imm", bus.idex_imm, 32'h123);
        chk("fl_acc_rt", bus.idex_rt, 10);
        chk("fl_acc_a", bus.idex_a, 32'hAA);
        // asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        chk("mr_valid", bus.idex_valid, 0);
        chk("mr_a", bus.idex_a, 0);
        chk("mr_ctl", bus.idex_ctl, 0);
        #2;
        rst_n = 1'b1; bus.ex_ready = 1'b1; bus.if_ir = r_ins(5, 5, 1);
        tick();
        chk("mr_acc_v", bus.idex_valid, 1);
        chk("mr_reg_a", bus.idex_a, 0);
        chk("mr_reg_b", bus.idex_b, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_stage_p.md
DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 Parameter DW, default 32: register/data width.
REQ-002 Parameter NREG, default 32: register count; AW = clog2(NREG).
REQ-003 Parameter PCW, default 12: next-PC width.
REQ-004 Parameter CTLW, default 9: control bundle width.
REQ-005 clk  input  1: single clock, rising edge.
REQ-006 rst_n  input  1: reset, asynchronous, active-low.
REQ-007 if_valid  input  1: IF/ID holds a valid instruction.
REQ-008 if_ir  input  32: instruction word.
REQ-009 if_npc  input  PCW: next PC of the instruction.
REQ-010 id_ready  output  1: stage accepts the IF/ID instruction this cycle.
REQ-011 ex_ready  input  1: EX accepts the ID/EX contents this cycle.
REQ-012 flush  input  1: kill the ID/EX contents and the incoming instruction.
REQ-013 wb_we, wb_addr, wb_data  input  1/AW/DW: write-back port.
REQ-014 idex_valid  output  1: ID/EX register is valid.
REQ-015 idex_a, idex_b, idex_imm  output  DW each: rs data, rt data, sign-extended imm[15:0].
REQ-016 idex_rt, idex_rd  output  AW each: ir[20:16], ir[15:11].
REQ-017 idex_npc  output  PCW; idex_ctl  output  CTLW.

Function
REQ-018 Control map: [8] RegDst, [7] ALUSrc, [6] MemtoReg, [5] RegWrite, [4] MemRead, [3] MemWrite, [2] Branch, [1:0] ALUOp.
REQ-019 Opcode decode: 000000 R -> 9'b100100010; 100011 LW -> 9'b011110000; 101011 SW -> 9'b010001000; 000100 BEQ -> 9'b000000101; 001000 ADDI -> 9'b010100000; any other opcode -> all zeros.
REQ-020 Register file: NREG x DW; reads combinational on rs = ir[25:21] and rt = ir[20:16]; register 0 reads as 0; writes to address 0 are ignored.
REQ-021 Write-through: when wb_we=1 and wb_addr equals a nonzero read address, that read returns wb_data in the same cycle.
REQ-022 Load-use hazard when all hold: idex_valid=1, idex_ctl[4]=1, idex_rt!=0, and idex_rt equals rs, or equals rt for an opcode using rt as a source (R, SW, BEQ).
REQ-023 advance = !idex_valid | ex_ready.
REQ-024 id_ready = advance & !hazard & !flush.
REQ-025 On an edge with advance=1 and flush=0:
  - hazard=0: ID/EX loads the decoded instruction; idex_valid = if_valid.
  - hazard=1: ID/EX loads a bubble (idex_valid=0, idex_ctl=0).
REQ-026 On an edge with advance=0 and flush=0: ID/EX holds all values.
REQ-027 On an edge with flush=1: idex_valid=0 and idex_ctl=0 regardless of ex_ready; the incoming instruction is not consumed.
REQ-028 A register-file write occurs on the edge when wb_we=1, independent of stall or flush.
REQ-029 Latency: one cycle from acceptance to idex_valid.
REQ-030 Stall length for a load-use hazard is exactly one cycle when ex_ready=1.
REQ-031 idex_imm = sign extension of ir[15:0] to DW.

Reset
REQ-032 While rst_n=0 (asynchronous):
  - idex_valid=0 and all idex_* outputs are 0.
  - all registers are 0.
REQ-033 id_ready is 1 in the first cycle after rst_n rises, provided flush=0.

Structure
REQ-034 A shared package holds:
  - opcode constants;
  - control-bit index constants and per-opcode control values;
  - DW/NREG/PCW/CTLW defaults.
REQ-035 Sub-module regfile_p (parametrised NREG x DW, 2R1W, write-through) is instantiated once; the opcode decoder stays inline.

Verification
REQ-036 Reset mid-stream: rst_n=0 while idex_valid=1 -> idex_valid=0 immediately and all registers read 0 afterwards.
REQ-037 Write-through: write R5=0x0000_00AA while an R-type instruction with rs=5 is decoded in the same cycle -> idex_a=0xAA on the next edge; a write to R0 leaves R0 reading 0.
REQ-038 Load-use: LW rt=3 in ID/EX, then R-type with rs=3 on IF/ID, ex_ready=1 -> id_ready=0 for 1 cycle, one bubble (idex_valid=0), then the R-type is accepted.
REQ-039 Backpressure: idex_valid=1, ex_ready=0 for 3 cycles -> id_ready=0 and ID/EX unchanged; the instruction is accepted on the first cycle with ex_ready=1.
REQ-040 Flush with stall: flush=1 together with ex_ready=0 -> idex_valid=0 next cycle, id_ready=0 during the flush cycle, and the IF/ID instruction is accepted one cycle later.
REQ-041 Sign extension: ADDI with imm 0xFFF0 -> idex_imm=0xFFFF_FFF0, idex_ctl=9'b010100000; undefined opcode 111111 -> idex_ctl=0.
